m_muldiv: RTL and testbench

M_MULDIV -- requirements
Module: m_muldiv

---
 rtl/m_muldiv_pkg.sv | 43 ++++
 rtl/m_div_iter.sv | 154 +++++++++++++++
 rtl/m_muldiv_defines.sv | 17 +
 rtl/m_muldiv.sv | 152 +++++++++++++++
 tb/tb_m_muldiv.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_muldiv_pkg.sv
// Shared types and helpers for the multiply/divide unit.
//   div_state_e      : iterative divider FSM states
//   prod_width()     : width of the signed internal product (2*XLEN+2)
//   MUL_STAGES_MIN/MAX : legal multiplier pipeline depths
//   is_mul/is_div/is_high : op-class decode of the `ALU_* codes
`include "m_muldiv_defines.sv"

package m_muldiv_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int MUL_STAGES_MIN = 1;
    localparam int MUL_STAGES_MAX = 4;

    // Both operands are widened by one bit so that every signedness mix
    // fits a single signed x signed multiply.
    function automatic int prod_width(input int xlen);
        return 2 * xlen + 2;
    endfunction

    localparam int XLEN_DEFAULT   = 32;
    localparam int PROD_W_DEFAULT = 2 * XLEN_DEFAULT + 2;

    function automatic logic is_mul(input logic [5:0] op);
        return (op == `ALU_MUL) || (op == `ALU_MULH) ||
               (op == `ALU_MULHSU) || (op == `ALU_MULHU);
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return (op == `ALU_DIV) || (op == `ALU_DIVU) ||
               (op == `ALU_REM) || (op == `ALU_REMU);
    endfunction

    // Ops that return the upper half of the product.
    function automatic logic is_high(input logic [5:0] op);
        return (op == `ALU_MULH) || (op == `ALU_MULHSU) || (op == `ALU_MULHU);
    endfunction

endpackage

// File: rtl/m_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle.
// Only compiled when M_DIV_EN is defined; otherwise no divider exists.
// Ports:
//   clk, rst (sync, active high), flush (sync kill)
//   in_valid/in_ready, in_op, in1 (dividend), in2 (divisor) : request
//   out_valid/out_ready, result                             : response
// FSM: IDLE -> CALC (XLEN cycles) -> DONE -> IDLE. Divide-by-zero and
// signed overflow go straight from IDLE to DONE.
`include "m_muldiv_defines.sv"

`ifdef M_DIV_EN
module m_div_iter
    import m_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             want_rem_q, want_rem_d;

    logic            signed_op, rem_op, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   rem_sh, diff;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        want_rem_d = want_rem_q;

        in_ready  = (state_q == DIV_IDLE);
        out_valid = (state_q == DIV_DONE);

        signed_op = (in_op == `ALU_DIV) || (in_op == `ALU_REM);
        rem_op    = (in_op == `ALU_REM) || (in_op == `ALU_REMU);
        a_neg     = signed_op & in1[XLEN-1];
        b_neg     = signed_op & in2[XLEN-1];
        a_mag     = a_neg ? -in1 : in1;
        b_mag     = b_neg ? -in2 : in2;

        // Quotient register doubles as the dividend shifter: its MSB feeds
        // the partial remainder and the new quotient bit enters at the LSB.
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};

        unique case (state_q)
            DIV_IDLE: begin
                if (in_valid) begin
                    want_rem_d = rem_op;
                    if (in2 == '0) begin
                        quo_d   = '1;
                        rem_d   = in1;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end else if (signed_op && in1 == {1'b1, {(XLEN-1){1'b0}}} &&
                                 in2 == '1) begin
                        quo_d   = in1;
                        rem_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end else begin
                        // Divide magnitudes; signs are applied on output.
                        quo_d   = a_mag;
                        rem_d   = '0;
                        dvs_d   = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = '0;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (flush) begin
            state_d = DIV_IDLE;
        end

        result = '0;
        if (state_q == DIV_DONE) begin
            if (want_rem_q) begin
                result = rneg_q ? -rem_q : rem_q;
            end else begin
                result = qneg_q ? -quo_q : quo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvs_q      <= dvs_d;
        qneg_q     <= qneg_d;
        rneg_q     <= rneg_d;
        want_rem_q <= want_rem_d;
    end

endmodule
`endif

// File: rtl/m_muldiv_defines.sv
// ALU operation codes shared by the integer datapath blocks.
// Only the M-extension codes are consumed by m_muldiv; any other value on
// in_op is treated as an unknown op.
// The guard lets this file be both compiled on its own and included.
`ifndef M_MULDIV_DEFINES_SV
`define M_MULDIV_DEFINES_SV

`define ALU_MUL    6'h20
`define ALU_MULH   6'h21
`define ALU_MULHSU 6'h22
`define ALU_MULHU  6'h23
`define ALU_DIV    6'h24
`define ALU_DIVU   6'h25
`define ALU_REM    6'h26
`define ALU_REMU   6'h27

`endif

// File: rtl/m_muldiv.sv
// RISC-V M-extension multiply/divide unit.
// Ports:
//   clk, rst (sync, active high), flush (sync kill of in-flight ops)
//   in_valid/in_ready, in_op (`ALU_*), in1, in2 : request
//   out_valid/out_ready, result                 : response (0 when idle)
// Multiplies run through a MUL_STAGES-deep pipe (one issue per cycle,
// in-order retire). Divides use m_div_iter when M_DIV_EN is defined;
// without it divide codes are unknown ops and return 0 via the mul pipe.
`include "m_muldiv_defines.sv"

module m_muldiv
    import m_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int PROD_W = prod_width(XLEN);
    localparam int LAST   = MUL_STAGES - 1;

    if (MUL_STAGES < MUL_STAGES_MIN || MUL_STAGES > MUL_STAGES_MAX) begin : g_bad_stages
        $error("m_muldiv: MUL_STAGES out of range");
    end

    // ---------------- multiply operand prep ----------------
    logic                     a_signed, b_signed;
    logic        [XLEN:0]     op_a, op_b;
    logic signed [PROD_W-1:0] op_a_x, op_b_x, prod;
    logic        [XLEN-1:0]   mul_res_in;
    logic                     unused_prod_hi;

    // The result is selected before the pipe so only XLEN bits travel down
    // it; the multiply itself is left for synthesis to retime across stages.
    always_comb begin
        a_signed   = (in_op != `ALU_MULHU);
        b_signed   = (in_op == `ALU_MUL) || (in_op == `ALU_MULH);
        op_a       = {a_signed & in1[XLEN-1], in1};
        op_b       = {b_signed & in2[XLEN-1], in2};
        op_a_x     = {{(PROD_W-XLEN-1){op_a[XLEN]}}, op_a};
        op_b_x     = {{(PROD_W-XLEN-1){op_b[XLEN]}}, op_b};
        prod       = op_a_x * op_b_x;
        mul_res_in = '0;
        if (is_mul(in_op)) begin
            mul_res_in = is_high(in_op) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    assign unused_prod_hi = ^prod[PROD_W-1:2*XLEN];

    // ---------------- issue control ----------------
    logic [MUL_STAGES-1:0]           mul_vld_q, mul_vld_d;
    logic [MUL_STAGES-1:0][XLEN-1:0] mul_res_q, mul_res_d;
    logic                            do_div, pipe_empty, stall, mul_acc;
    logic                            div_in_ready, div_out_valid;
    logic [XLEN-1:0]                 div_result;

`ifdef M_DIV_EN
    assign do_div = is_div(in_op);
`else
    assign do_div = 1'b0;
`endif

    assign pipe_empty = ~|mul_vld_q;
    // Head of the pipe waiting on the consumer freezes every stage.
    assign stall      = mul_vld_q[LAST] & ~out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (do_div) begin
            in_ready = div_in_ready & pipe_empty;
        end else begin
            in_ready = div_in_ready & ~stall;
        end
    end

    assign mul_acc = in_valid & in_ready & ~do_div;

    // ---------------- multiply pipe ----------------
    always_comb begin
        mul_vld_d = mul_vld_q;
        mul_res_d = mul_res_q;
        if (!stall) begin
            mul_vld_d[0] = mul_acc;
            mul_res_d[0] = mul_res_in;
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_vld_d[i] = mul_vld_q[i-1];
                mul_res_d[i] = mul_res_q[i-1];
            end
        end
        // Also discards an accept in the same cycle.
        if (flush) begin
            mul_vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_vld_q <= '0;
        end else begin
            mul_vld_q <= mul_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        mul_res_q <= mul_res_d;
    end

    // ---------------- divider ----------------
`ifdef M_DIV_EN
    logic div_in_valid;
    assign div_in_valid = in_valid & do_div & pipe_empty;

    m_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (div_in_valid),
        .in_ready (div_in_ready),
        .in_op    (in_op),
        .in1      (in1),
        .in2      (in2),
        .out_valid(div_out_valid),
        .out_ready(out_ready),
        .result   (div_result)
    );
`else
    assign div_in_ready  = 1'b1;
    assign div_out_valid = 1'b0;
    assign div_result    = '0;
`endif

    // ---------------- response ----------------
    // The issue rule keeps the two sources mutually exclusive; the divider
    // already drives 0 while it has nothing to return.
    assign out_valid = mul_vld_q[LAST] | div_out_valid;
    assign result    = mul_vld_q[LAST] ? mul_res_q[LAST] : div_result;

endmodule

// File: tb/tb_m_muldiv.sv
module tb_m_muldiv;

    localparam int XLEN = 32;
    localparam int MS   = 2;

    localparam logic [5:0] OP_MUL    = 6'h20;
    localparam logic [5:0] OP_MULH   = 6'h21;
    localparam logic [5:0] OP_MULHSU = 6'h22;
    localparam logic [5:0] OP_MULHU  = 6'h23;
    localparam logic [5:0] OP_DIV    = 6'h24;
    localparam logic [5:0] OP_DIVU   = 6'h25;
    localparam logic [5:0] OP_REM    = 6'h26;
    localparam logic [5:0] OP_REMU   = 6'h27;
    localparam logic [5:0] OP_BAD    = 6'h00;

    logic            clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]      in_op;
    logic [XLEN-1:0] in1, in2, result;

    m_muldiv #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          lat;
        int          acc;
    } sb_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Scoreboard check on every retire.
    always @(negedge clk) begin
        sb_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: got result %h with nothing outstanding", result);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_val"}, result, e.exp);
                if (e.lat >= 0) chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Drives a request (in_valid left high) and waits for accept.
    task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         output int waited);
        sb_t e;
        bit  done;
        done = 0;
        waited = 0;
        in_valid = 1'b1; in_op = op; in1 = a; in2 = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.name = name; e.exp = exp; e.lat = lat; e.acc = cyc;
                sb.push_back(e);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_accept: in_ready stayed 0, want 1 within 200 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1;
        end
        @(posedge clk); #1;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: %0d results outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic count_out(input int n, output int ov);
        ov = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int ov;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = OP_MUL;
        in1 = '0; in2 = '0; out_ready = 1'b1;

        add("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MS);
        add("mul_min",    OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, MS);
        add("mulhsu_one", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MS);
        add("mulhu_one",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MS);
        add("mul_small",  OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MS);
        add("mulh_max",   OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, MS);
        add("mulh_neg1",  OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MS);
        add("mulhu_2",    OP_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, MS);
        add("mulhsu_neg", OP_MULHSU, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, MS);
        add("unknown_op", OP_BAD,    32'h0000_0005, 32'h0000_0006, 32'h0000_0000, MS);
`ifdef M_DIV_EN
        add("div_m7_2",   OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, XLEN + 1);
        add("rem_m7_2",   OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, XLEN + 1);
        add("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        add("divu_by0",   OP_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        add("remu_by0",   OP_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1);
        add("div_by0",    OP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        add("div_7_m2",   OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, XLEN + 1);
        add("rem_7_m2",   OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, XLEN + 1);
        add("div_min_3",  OP_DIV,    32'h8000_0000, 32'h0000_0003, 32'hD555_5556, XLEN + 1);
        add("rem_min_3",  OP_REM,    32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, XLEN + 1);
        add("divu_100_7", OP_DIVU,   32'd100,       32'd7,         32'd14,        XLEN + 1);
        add("remu_100_7", OP_REMU,   32'd100,       32'd7,         32'd2,         XLEN + 1);
        add("divu_max_1", OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, XLEN + 1);
`else
        add("div_as_unk", OP_DIV,    32'd6,         32'd3,         32'd0,         MS);
        add("remu_as_unk", OP_REMU,  32'd7,         32'd0,         32'd0,         MS);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready_mul", 32'(in_ready), 32'd1);
        in_op = OP_DIV; #1;
        chk("post_rst_in_ready_div", 32'(in_ready), 32'd1);
        in_op = OP_MUL;
        @(posedge clk); #1;

        // Single-op vectors
        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, w);
            in_valid = 1'b0;
            wait_drain(vecs[i].name);
        end
        @(negedge clk);
        chk("idle_result", result, 32'd0);
        @(posedge clk); #1;

        // Back-to-back multiplies with a 3-cycle consumer stall
        issue("s0", OP_MUL, 32'd3, 32'd5, 32'd15, -1, w);
        issue("s1", OP_MUL, 32'd7, 32'd9, 32'd63, -1, w);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_MUL; in1 = 32'd2; in2 = 32'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_result", result, 32'd15);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue("s2", OP_MUL, 32'd2, 32'd2, 32'd4, -1, w);
        issue("s3", OP_MUL, 32'd1, 32'd0, 32'd0, -1, w);
        in_valid = 1'b0;
        wait_drain("stream");

        // Flush of a multiply in flight
        issue("fl_mul", OP_MUL, 32'd3, 32'd5, 32'd15, MS, w);
        in_valid = 1'b0;
        flush = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        count_out(10, ov);
        chk("fl_mul_no_out", 32'(ov), 32'd0);

        // Accept in the same cycle as flush is discarded
        in_valid = 1'b1; in_op = OP_MUL; in1 = 32'd4; in2 = 32'd4; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        count_out(10, ov);
        chk("fl_acc_no_out", 32'(ov), 32'd0);

`ifdef M_DIV_EN
        // Multiply held off while a divide is busy
        issue("ho_div", OP_DIVU, 32'd100, 32'd7, 32'd14, XLEN + 1, w);
        issue("ho_mul", OP_MUL, 32'd3, 32'd5, 32'd15, MS, w);
        in_valid = 1'b0;
        chk("ho_wait_cycles", 32'(w), 32'(XLEN + 1));
        wait_drain("holdoff");

        // Flush 10 cycles into a divide
        issue("fl_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, XLEN + 1, w);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_div_out_valid", 32'(out_valid), 32'd0);
        chk("fl_div_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        count_out(40, ov);
        chk("fl_div_no_out", 32'(ov), 32'd0);

        // Reset in the middle of a divide
        issue("rst_div", OP_DIVU, 32'd100, 32'd7, 32'd14, XLEN + 1, w);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_div_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        count_out(40, ov);
        chk("rst_div_no_out", 32'(ov), 32'd0);
`endif

        // Unit still works after the corner cases
        issue("final_mul", OP_MUL, 32'd6, 32'd7, 32'd42, MS, w);
        in_valid = 1'b0;
        wait_drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
